hc_scan: RTL and testbench
==========================

Name: hc_scan

Overview:
- Round-robin scan controller: shares one sensor-sample port across NCH channels; each channel is a pair of temperature readings (ts1, ts2).
- Fetches both readings of a channel over a req/ack handshake, applies the 1-greater-than-2 hysteresis decision and holds one decision bit per channel.
- Sits between the sensor-sample interface and the thermal/alarm logic; replaces per-channel comparator instances.

Parameters:
- NCH, 4, number of channels (2..16); sensor address = 2*ch for ts1, 2*ch+1 for ts2
- W, 8, sample width in bits
- TH, 10, hysteresis threshold, unsigned, < 2^W
- TMO, 15, max cycles to wait for adc_ack per request (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  scan enable
- err_clr  in  1  one-cycle pulse, clears err
- adc_req  out  1  sample request
- adc_sel  out  clog2(2*NCH)  sensor address, stable while adc_req high
- adc_ack  in  1  sample-valid acknowledge
- adc_data  in  W  sample value, valid when adc_ack high
- out  out  NCH  per-channel decision, 1 = ts1 exceeds ts2 by more than TH
- upd  out  1  one-cycle pulse, out[upd_ch] just re-evaluated
- upd_ch  out  clog2(NCH)  channel of last evaluation
- scan_done  out  1  one-cycle pulse after last channel handled
- err  out  NCH  sticky per-channel timeout flags

Behaviour:
- Reset (rst low, async): state IDLE; ch=0; out=0; err=0; adc_req=0; adc_sel=0; upd=0; upd_ch=0; scan_done=0; sample regs a=b=0; timeout counter 0.
- States: IDLE, REQ_A, REQ_B, EVAL, NEXT.
- IDLE: adc_req=0. en=1 -> REQ_A with ch=0. en is sampled only in IDLE and at scan wrap; deasserting en mid-scan lets the current scan finish.
- REQ_A: adc_req=1, adc_sel=2*ch. The transfer completes on a rising edge where adc_req=1 and adc_ack=1: a<=adc_data, go REQ_B. adc_req stays high through REQ_B, so back-to-back transfers are allowed; adc_sel changes on the same edge.
- REQ_B: same handshake with adc_sel=2*ch+1. On the ack edge: b<=adc_data, go EVAL.
- adc_ack while adc_req=0 is ignored.
- Timeout: the counter clears on entry to REQ_A/REQ_B and increments every cycle without ack. When it reaches TMO with no ack:
  - err[ch]<=1
  - out[ch] unchanged, no upd pulse
  - go NEXT
  - If ack arrives in the same cycle the counter reaches TMO, the ack wins.
- EVAL (1 cycle): compare in W+1 bits, no wrap.
  - out[ch]=0 and a > b+TH -> out[ch]<=1
  - out[ch]=1 and a+TH < b -> out[ch]<=0
  - otherwise hold
  - upd=1 and upd_ch=ch in the cycle after EVAL (registered). Go NEXT.
- NEXT (1 cycle): if ch<NCH-1: ch<=ch+1, go REQ_A. Else ch<=0, scan_done pulses next cycle; go REQ_A if en=1, else IDLE.
- Latency per channel with zero-wait ack: REQ_A 1 + REQ_B 1 + EVAL 1 + NEXT 1 = 4 cycles; full scan = 4*NCH cycles.
- err_clr clears all err bits. If err_clr and a timeout set coincide for the same bit, the set wins.
- out and err hold their values across IDLE; only reset clears out.
- Reset asserted mid-transfer drops adc_req asynchronously. A pending ack after reset release is ignored, because adc_req=0 in IDLE.

Test Plan:
- Reset/idle: rst low with en=1 and stray acks -> out=0, err=0, adc_req=0; after release with en=0, adc_req remains 0 for 20 cycles.
- Hysteresis ch0, zero-wait ack:
  - (a,b) = (50,40) -> out[0] stays 0
  - (51,40) -> out[0]=1, with upd pulse and upd_ch=0
  - (35,45) -> stays 1
  - (34,45) -> out[0]=0
- Boundary, no wrap: (5,250) with out=0 -> stays 0. (250,5) -> sets 1. (0,9) with out=1 -> stays 1. (0,11) -> clears 0.
- Full scan NCH=4, ack in the same cycle as req:
  - adc_sel sequence 0,1,2,3,4,5,6,7
  - scan_done at cycle 16 after start
  - second scan begins immediately while en=1
  - en dropped mid-scan -> scan completes, then IDLE.
- Timeout: withhold ack on sel=3 for 15 cycles:
  - err[1]=1, out[1] unchanged, no upd for ch1
  - scan proceeds to sel=4
  - err_clr pulse -> err=0
  - ack exactly at cycle 15 -> no error.
- Async reset mid REQ_B: adc_req drops immediately without a clock edge; out and err clear; next scan restarts at sel=0.

Source files
------------

// File: rtl/hc_scan.sv
// hc_scan: round-robin scanner sharing one sensor port across NCH channels.
// Fetches (ts1, ts2) per channel and keeps a hysteresis decision bit each.
module hc_scan #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int TH  = 10,
  parameter int TMO = 15,
  localparam int SW = $clog2(2*NCH),
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           err_clr,
  output logic           adc_req,
  output logic [SW-1:0]  adc_sel,
  input  logic           adc_ack,
  input  logic [W-1:0]   adc_data,
  output logic [NCH-1:0] out,
  output logic           upd,
  output logic [CW-1:0]  upd_ch,
  output logic           scan_done,
  output logic [NCH-1:0] err
);

  typedef enum logic [2:0] {
    IDLE, REQ_A, REQ_B, EVAL, NEXT
  } st_t;

  localparam logic [7:0] TLIM = 8'(TMO - 1);
  localparam logic [W:0] THW  = (W+1)'(TH);

  st_t           st, nst;
  logic [CW-1:0] ch;
  logic [W-1:0]  a, b;
  logic [7:0]    tcnt;
  logic          last;
  logic          tmo;
  logic          dec;
  logic [NCH-1:0] eset;
  logic [W:0]    aw, bw;

  assign last    = (ch == CW'(NCH - 1));
  assign adc_sel = {ch, st == REQ_B};
  assign aw      = {1'b0, a};
  assign bw      = {1'b0, b};

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nst;
  end

  // next state, request strobe, timeout and decision
  always_comb begin
    nst     = st;
    adc_req = 1'b0;
    tmo     = 1'b0;
    eset    = '0;
    dec     = out[ch];
    unique case (st)
      IDLE: begin
        if (en) nst = REQ_A;
      end
      REQ_A: begin
        adc_req = 1'b1;
        if (adc_ack) nst = REQ_B;
        else if (tcnt == TLIM) begin
          tmo = 1'b1;
          nst = NEXT;
        end
      end
      REQ_B: begin
        adc_req = 1'b1;
        if (adc_ack) nst = EVAL;
        else if (tcnt == TLIM) begin
          tmo = 1'b1;
          nst = NEXT;
        end
      end
      EVAL: begin
        nst = NEXT;
        if (!out[ch] && (aw > bw + THW)) dec = 1'b1;
        else if (out[ch] && (aw + THW < bw)) dec = 1'b0;
      end
      NEXT: begin
        if (!last || en) nst = REQ_A;
        else nst = IDLE;
      end
      default: nst = IDLE;
    endcase
    if (tmo) eset[ch] = 1'b1;
  end

  // channel pointer, samples, wait counter, decisions and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch        <= '0;
      a         <= '0;
      b         <= '0;
      tcnt      <= '0;
      out       <= '0;
      err       <= '0;
      upd       <= 1'b0;
      upd_ch    <= '0;
      scan_done <= 1'b0;
    end else begin
      upd       <= (st == EVAL);
      scan_done <= (st == NEXT) && last;
      err       <= (err & ~{NCH{err_clr}}) | eset;
      if (adc_req && !adc_ack && !tmo) tcnt <= tcnt + 8'd1;
      else tcnt <= '0;
      if (st == REQ_A && adc_ack) a <= adc_data;
      if (st == REQ_B && adc_ack) b <= adc_data;
      if (st == EVAL) begin
        out[ch] <= dec;
        upd_ch  <= ch;
      end
      if (st == NEXT) ch <= last ? '0 : ch + CW'(1);
    end
  end

endmodule

// File: tb/tb_hc_scan.sv
// tb_hc_scan: random sensor responder with a scoreboard of expected
// per-channel decisions, plus directed hysteresis, timeout and reset cases.
module tb_hc_scan;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int TH  = 10;
  localparam int TMO = 15;
  localparam int SW  = $clog2(2*NCH);
  localparam int CW  = $clog2(NCH);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           err_clr = 1'b0;
  logic           adc_ack = 1'b0;
  logic [W-1:0]   adc_data = '0;
  logic           adc_req;
  logic [SW-1:0]  adc_sel;
  logic [NCH-1:0] out;
  logic           upd;
  logic [CW-1:0]  upd_ch;
  logic           scan_done;
  logic [NCH-1:0] err;

  always #5 clk = ~clk;

  hc_scan #(.NCH(NCH), .W(W), .TH(TH), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr),
    .adc_req(adc_req), .adc_sel(adc_sel),
    .adc_ack(adc_ack), .adc_data(adc_data),
    .out(out), .upd(upd), .upd_ch(upd_ch),
    .scan_done(scan_done), .err(err)
  );

  typedef struct {
    int             ch;
    logic [NCH-1:0] ov;
  } exp_t;

  exp_t sbq[$];
  int   dq[$];
  int   dexp[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_hand = 0;
  int   n_done = 0;

  logic [NCH-1:0] m_out = '0;
  logic [NCH-1:0] m_err = '0;
  int m_pos = 0;
  int m_a = 0;
  int cur_v = 0;

  int zero_wait = 1;
  int force_sel = -1;
  int force_d = 0;
  bit active = 0;
  bit acked = 0;
  int w = 0;
  int d = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int pick();
    int v;
    if (m_pos < 2 && dq.size() > 0) v = dq.pop_front();
    else if (m_pos % 2 == 0) v = int'($urandom_range(0, (1 << W) - 1));
    else begin
      v = m_a + int'($urandom_range(0, 2*TH + 8)) - (TH + 4);
      if (v < 0) v = 0;
      if (v > (1 << W) - 1) v = (1 << W) - 1;
    end
    return v;
  endfunction

  // sensor responder and reference model
  initial begin
    exp_t e;
    int   c;
    int   r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        adc_ack  = 1'($urandom_range(0, 1));
        adc_data = W'($urandom);
        active = 0;
        acked  = 0;
        m_out  = '0;
        m_err  = '0;
        m_pos  = 0;
        sbq.delete();
        n_hand -= n_hand % NCH;
      end else begin
        if (acked) begin
          acked  = 0;
          active = 0;
          if (m_pos % 2 == 0) begin
            m_a = cur_v;
            m_pos++;
          end else begin
            c = m_pos / 2;
            if (!m_out[c] && m_a - cur_v > TH) m_out[c] = 1'b1;
            else if (m_out[c] && cur_v - m_a > TH) m_out[c] = 1'b0;
            e.ch = c;
            e.ov = m_out;
            sbq.push_back(e);
            n_hand++;
            m_pos = ((c + 1) % NCH) * 2;
          end
        end
        adc_ack = 1'b0;
        if (active && w == TMO) begin
          c = m_pos / 2;
          m_err[c] = 1'b1;
          active = 0;
          n_hand++;
          m_pos = ((c + 1) % NCH) * 2;
          chk("err_after_timeout", err, m_err);
        end
        if (adc_req && !active) begin
          chk("adc_sel", adc_sel, m_pos);
          active = 1;
          w = 0;
          if (force_sel == m_pos) begin
            d = force_d;
            force_sel = -1;
          end else if (zero_wait != 0) d = 0;
          else begin
            r = int'($urandom_range(0, 99));
            if (r < 60) d = 0;
            else if (r < 92) d = int'($urandom_range(1, 3));
            else if (r < 96) d = TMO - 1;
            else d = TMO;
          end
        end
        if (active) begin
          if (w == d) begin
            cur_v = pick();
            adc_data = W'(cur_v);
            adc_ack = 1'b1;
            acked = 1;
          end else w++;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && upd) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL upd_unexpected: upd_ch=%0d out=%0d", upd_ch, out);
        end else begin
          e = sbq.pop_front();
          chk("upd_ch", upd_ch, e.ch);
          chk("out", out, e.ov);
        end
        if (upd_ch == 0 && dexp.size() > 0)
          chk("ch0_directed", out[0], dexp.pop_front());
      end
      if (rst && scan_done) n_done++;
    end
  end

  task automatic wait_scans(input int n);
    int tgt;
    int t;
    tgt = n_done + n;
    t = 0;
    while (n_done < tgt && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (n_done < tgt) begin
      n_vec++;
      n_bad++;
      $display("FAIL scan_wait: %0d of %0d scans seen", n_done, tgt);
    end
  endtask

  task automatic wait_idle();
    int q;
    int t;
    q = 0;
    t = 0;
    while (q < 8 && t < 5000) begin
      @(negedge clk);
      q = adc_req ? 0 : q + 1;
      t++;
    end
    if (q < 8) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_wait: adc_req still active after %0d", t);
    end
  endtask

  initial begin
    int hi;
    int t;
    int cyc;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_err", err, 0);
    chk("rst_req", adc_req, 0);
    chk("rst_sel", adc_sel, 0);
    chk("rst_upd", upd, 0);
    chk("rst_done", scan_done, 0);
    en = 1'b0;
    #2 rst = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (adc_req) hi++;
    end
    chk("idle_no_req", hi, 0);

    dq = '{50, 40, 51, 40, 35, 45, 34, 45,
           5, 250, 250, 5, 0, 9, 0, 11};
    dexp = '{0, 1, 1, 0, 0, 1, 1, 0};
    zero_wait = 1;
    en = 1'b1;
    t = 0;
    while (!adc_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    cyc = 0;
    while (!scan_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("scan_latency", cyc, 4 * NCH);
    chk("rescan_req", adc_req, 1);
    chk("rescan_sel", adc_sel, 0);
    wait_scans(8);
    chk("directed_done", dexp.size(), 0);

    force_d = TMO;
    force_sel = 3;
    wait_scans(2);
    chk("timeout_err1", err, 4'b0010);

    @(negedge clk);
    err_clr = 1'b1;
    m_err = '0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_run", err, 0);
    force_d = TMO - 1;
    force_sel = 2;
    wait_scans(2);
    chk("ack_at_limit", err, 0);

    zero_wait = 0;
    wait_scans(40);

    t = 0;
    while (!(adc_req && adc_sel == 2) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    en = 1'b0;
    wait_idle();
    chk("scan_complete", n_hand % NCH, 0);
    chk("sb_empty", sbq.size(), 0);
    chk("done_count", n_done, n_hand / NCH);
    err_clr = 1'b1;
    m_err = '0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_idle", err, 0);

    en = 1'b1;
    wait_scans(3);
    t = 0;
    while (!(adc_req && adc_sel == 5) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    #2 rst = 1'b0;
    #1;
    chk("async_req", adc_req, 0);
    chk("async_out", out, 0);
    chk("async_err", err, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    wait_scans(2);
    en = 1'b0;
    wait_idle();
    chk("final_sb_empty", sbq.size(), 0);
    chk("final_done", n_done, n_hand / NCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
